block_code_frame_sched: RTL
===========================

Name: block_code_frame_sched

Overview:
- Sits between the soft-symbol input stream and the block-code decoder core inside top_block_code.
- Groups incoming soft symbols into codewords of code_length symbols and buffers them in a two-bank ping-pong store.
- Issues one decode job per full bank, streams that codeword to the core and waits for its completion.
- Releases the bank on completion, or on a watchdog timeout, and reports drop and error status.

Parameters:
- DATA_WIDTH, 4, soft-symbol width in bits.
- MAX_LEN, 15, symbols per bank; code_length must not exceed it.
- TIMEOUT, 1024, cycles allowed in WAIT before a forced bank release.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_symbols  in  DATA_WIDTH  soft symbol.
- rx_symbols_valid  in  1  rx_symbols is valid this cycle.
- rx_symbols_ready  out  1  scheduler can accept a symbol; combinational = !full[wr_bank].
- code_length  in  4  codeword length; sampled with the first symbol of each codeword.
- dec_start  out  1  one-cycle pulse that opens a decode job.
- dec_length  out  4  length of the current job; held from dec_start until release.
- dec_symbol  out  DATA_WIDTH  symbol sent to the core.
- dec_symbol_idx  out  4  position of dec_symbol inside the codeword.
- dec_symbol_valid  out  1  dec_symbol and dec_symbol_idx are valid.
- dec_done  in  1  pulse from the core: job finished.
- frame_cnt  out  16  count of released codewords; wraps 0xFFFF -> 0.
- drop_cnt  out  16  symbols presented while ready=0; saturates at 0xFFFF.
- cfg_err  out  1  sticky; a codeword was started with code_length < 2 or > MAX_LEN.
- timeout_err  out  1  sticky; a WAIT timed out.

Behaviour:
- Reset (synchronous, same clock edge): both banks empty, wr_bank=rd_bank=0, wr_idx=0, FSM in IDLE. Outputs: dec_start=0, dec_symbol_valid=0, dec_symbol=0, dec_symbol_idx=0, dec_length=0, frame_cnt=0, drop_cnt=0, cfg_err=0, timeout_err=0. Reset mid-job drops everything in flight; the core gets no extra pulse.
- Write side:
  - A symbol is accepted when rx_symbols_valid && rx_symbols_ready.
  - If wr_idx==0 at acceptance, code_length is latched into len[wr_bank].
  - The symbol is written to bank[wr_bank][wr_idx], then wr_idx increments.
  - When the accepted symbol is at index len-1: full[wr_bank] is set on that edge, wr_bank toggles and wr_idx returns to 0.
  - code_length changes during a codeword are ignored until the next codeword.
- Invalid length: if code_length is 0, 1 or > MAX_LEN when it would be latched, that symbol is discarded, cfg_err is set and wr_idx stays 0.
- Drops: valid && !ready increments drop_cnt; the symbol is lost.
- Read FSM, IDLE -> START -> STREAM -> WAIT -> IDLE:
  - IDLE: if full[rd_bank], go to START; dec_start=1 and dec_length=len[rd_bank] are registered on the same edge.
  - START lasts one cycle, then STREAM.
  - STREAM: one symbol per cycle, idx 0..len-1, registered, dec_symbol_valid=1. After idx len-1 go to WAIT.
  - WAIT: on dec_done, clear full[rd_bank], toggle rd_bank, increment frame_cnt, go to IDLE. After TIMEOUT cycles without dec_done, do the same and also set timeout_err.
  - dec_done outside WAIT is ignored.
- Latency, with the last symbol of a codeword accepted at edge E0:
  - dec_start is high E1..E2.
  - idx 0 is valid E2..E3; idx L-1 is valid E(L+1)..E(L+2).
  - If dec_done is sampled at edge Ed, the release happens at Ed. If the other bank is already full, the next dec_start is high Ed+1..Ed+2.
- Backpressure:
  - Bank release and write acceptance never touch the same bank in one cycle.
  - A bank released at edge Ed reads as ready in the cycle after Ed.
  - With both banks full, ready=0 until a release.
- Store: 2 x MAX_LEN x DATA_WIDTH registers; no RAM inference required.

Test Plan:
- Single codeword: code_length=13, symbols 0..12 back-to-back, dec_done pulsed 3 cycles after idx 12. Required: dec_start exactly 1 cycle after the last accept; dec_symbol 0..12 with idx 0..12 on consecutive cycles; dec_length=13; frame_cnt=1; drop_cnt=0.
- Ping-pong and backpressure: 3 codewords of length 13 streamed continuously, decoder answers dec_done 40 cycles after each dec_start. Required: ready=0 after 26 accepts; valid held high while ready=0 increments drop_cnt by exactly the stall cycles; frame_cnt=3; symbols come out in order.
- Length change: code_length=13 for symbol 0, changed to 7 at symbol 5. Required: first job dec_length=13; next codeword dec_length=7 with 7 symbols streamed.
- Invalid length: code_length=1, 4 symbols presented. Required: cfg_err=1; no dec_start; wr_idx stays 0. Then code_length=4 with symbols 3,2,1,0: one job, dec_length=4.
- Timeout: TIMEOUT=16, one codeword, dec_done never asserted. Required: release 16 cycles into WAIT; timeout_err=1; frame_cnt=1; a dec_done pulse arriving afterwards in IDLE has no effect.
- Reset mid-stream: rst high for 1 cycle during STREAM at idx 5. Required: next cycle dec_symbol_valid=0, all counters 0, ready=1; a following clean codeword decodes normally.

Source files
------------

// File: rtl/block_code_frame_sched.sv
// Frame scheduler between the soft-symbol stream and the block-code decoder core.
// Collects symbols into codewords in a two-bank ping-pong store, launches one
// decode job per full bank, streams the codeword out and releases the bank on
// dec_done or on a watchdog timeout.
module block_code_frame_sched #(
   parameter int DATA_WIDTH = 4,
   parameter int MAX_LEN    = 15,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] rx_symbols,
   input  logic                  rx_symbols_valid,
   output logic                  rx_symbols_ready,
   input  logic [3:0]            code_length,
   output logic                  dec_start,
   output logic [3:0]            dec_length,
   output logic [DATA_WIDTH-1:0] dec_symbol,
   output logic [3:0]            dec_symbol_idx,
   output logic                  dec_symbol_valid,
   input  logic                  dec_done,
   output logic [15:0]           frame_cnt,
   output logic [15:0]           drop_cnt,
   output logic                  cfg_err,
   output logic                  timeout_err
);

   localparam int              TW        = $clog2(TIMEOUT + 1);
   localparam logic [3:0]      MAX_LEN_C = 4'(MAX_LEN);
   localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_WAIT} state_t;

   // symbol store: contents are only meaningful while the bank's full flag is set
   logic [DATA_WIDTH-1:0] mem_q [0:1][0:MAX_LEN-1];

   state_t                state_q, state_d;
   logic [1:0][3:0]       len_q, len_d;
   logic [1:0]            full_q, full_d;
   logic                  wr_bank_q, wr_bank_d;
   logic [3:0]            wr_idx_q, wr_idx_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [3:0]            rd_idx_q, rd_idx_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  dec_start_q, dec_start_d;
   logic [3:0]            dec_len_q, dec_len_d;
   logic [DATA_WIDTH-1:0] dec_sym_q, dec_sym_d;
   logic [3:0]            dec_idx_q, dec_idx_d;
   logic                  dec_vld_q, dec_vld_d;
   logic [15:0]           frame_q, frame_d;
   logic [15:0]           drop_q, drop_d;
   logic                  cfg_q, cfg_d;
   logic                  to_q, to_d;

   logic                  acc, len_bad, we, set_full, clr_full;

   // The write bank is never the bank being read while it is full, so accept
   // and release cannot collide on one bank.
   assign rx_symbols_ready = !full_q[wr_bank_q];
   assign acc              = rx_symbols_valid && rx_symbols_ready;
   assign len_bad          = (code_length < 4'd2) || (code_length > MAX_LEN_C);

   // Write side: length latch on first symbol, bank fill, drop/config accounting
   always_comb begin
      wr_bank_d = wr_bank_q;
      wr_idx_d  = wr_idx_q;
      len_d     = len_q;
      cfg_d     = cfg_q;
      drop_d    = drop_q;
      we        = 1'b0;
      set_full  = 1'b0;
      if (rx_symbols_valid && !rx_symbols_ready && drop_q != 16'hFFFF)
         drop_d = drop_q + 16'd1;
      if (acc) begin
         if (wr_idx_q == 4'd0 && len_bad) begin
            cfg_d = 1'b1;  // symbol discarded, stay at the codeword start
         end else begin
            we = 1'b1;
            if (wr_idx_q == 4'd0)
               len_d[wr_bank_q] = code_length;
            // index 0 can never be the last symbol since lengths are >= 2
            if (wr_idx_q != 4'd0 && wr_idx_q == len_q[wr_bank_q] - 4'd1) begin
               set_full  = 1'b1;
               wr_bank_d = ~wr_bank_q;
               wr_idx_d  = 4'd0;
            end else begin
               wr_idx_d = wr_idx_q + 4'd1;
            end
         end
      end
   end

   // Store write for accepted, non-discarded symbols
   always_ff @(posedge clk) begin
      if (we)
         mem_q[wr_bank_q][wr_idx_q] <= rx_symbols;
   end

   // Read FSM: launch job, stream the codeword, wait for completion or watchdog
   always_comb begin
      state_d     = state_q;
      rd_bank_d   = rd_bank_q;
      rd_idx_d    = rd_idx_q;
      timer_d     = timer_q;
      dec_start_d = 1'b0;
      dec_len_d   = dec_len_q;
      dec_sym_d   = dec_sym_q;
      dec_idx_d   = dec_idx_q;
      dec_vld_d   = 1'b0;
      frame_d     = frame_q;
      to_d        = to_q;
      clr_full    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (full_q[rd_bank_q]) begin
               state_d     = S_START;
               dec_start_d = 1'b1;
               dec_len_d   = len_q[rd_bank_q];
            end
         end
         S_START: begin
            dec_sym_d = mem_q[rd_bank_q][0];
            dec_idx_d = 4'd0;
            dec_vld_d = 1'b1;
            rd_idx_d  = 4'd1;
            state_d   = S_STREAM;
         end
         S_STREAM: begin
            if (rd_idx_q == dec_len_q) begin
               state_d = S_WAIT;
               timer_d = '0;
            end else begin
               dec_sym_d = mem_q[rd_bank_q][rd_idx_q];
               dec_idx_d = rd_idx_q;
               dec_vld_d = 1'b1;
               rd_idx_d  = rd_idx_q + 4'd1;
            end
         end
         S_WAIT: begin
            if (dec_done || timer_q == TO_LAST) begin
               clr_full  = 1'b1;
               rd_bank_d = ~rd_bank_q;
               frame_d   = frame_q + 16'd1;
               state_d   = S_IDLE;
               if (!dec_done)
                  to_d = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bank occupancy: release and fill always target different banks
   always_comb begin
      full_d = full_q;
      if (clr_full)
         full_d[rd_bank_q] = 1'b0;
      if (set_full)
         full_d[wr_bank_q] = 1'b1;
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         wr_idx_q    <= '0;
         rd_bank_q   <= 1'b0;
         rd_idx_q    <= '0;
         timer_q     <= '0;
         dec_start_q <= 1'b0;
         dec_len_q   <= '0;
         dec_sym_q   <= '0;
         dec_idx_q   <= '0;
         dec_vld_q   <= 1'b0;
         frame_q     <= '0;
         drop_q      <= '0;
         cfg_q       <= 1'b0;
         to_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         wr_idx_q    <= wr_idx_d;
         rd_bank_q   <= rd_bank_d;
         rd_idx_q    <= rd_idx_d;
         timer_q     <= timer_d;
         dec_start_q <= dec_start_d;
         dec_len_q   <= dec_len_d;
         dec_sym_q   <= dec_sym_d;
         dec_idx_q   <= dec_idx_d;
         dec_vld_q   <= dec_vld_d;
         frame_q     <= frame_d;
         drop_q      <= drop_d;
         cfg_q       <= cfg_d;
         to_q        <= to_d;
      end
   end

   assign dec_start        = dec_start_q;
   assign dec_length       = dec_len_q;
   assign dec_symbol       = dec_sym_q;
   assign dec_symbol_idx   = dec_idx_q;
   assign dec_symbol_valid = dec_vld_q;
   assign frame_cnt        = frame_q;
   assign drop_cnt         = drop_q;
   assign cfg_err          = cfg_q;
   assign timeout_err      = to_q;

endmodule
